// File: rtl/rom_arbiter.sv
// rom_arbiter
//   Shares the single-port synchronous instruction ROM between the fetch
//   path (i_*) and the data-bus load path (d_*). At most one ROM read is
//   issued per cycle; on conflict the port that did not win last time is
//   granted. Read data (1-cycle latency) is steered back to the port that
//   issued the read.
//
// Ports
//   clk, rst_n            core clock, asynchronous active-low reset
//   i_req/i_addr/i_flush  fetch request, word address, fetch redirect
//   i_gnt/i_rvalid/i_rdata fetch grant (combinational), response valid/data
//   d_req/d_addr          data-bus read request and word address
//   d_gnt/d_rvalid/d_rdata data grant (combinational), response valid/data
//   rom_rd_en/rom_addr    ROM read strobe and word address
//   rom_rd_data           ROM data, valid the cycle after rom_rd_en
//   conflict_cnt          saturating count of both-requesting cycles
module rom_arbiter #(
  parameter int ROM_ADDR_WIDTH = 10,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_req,
  input  logic [ROM_ADDR_WIDTH-1:0] i_addr,
  input  logic                      i_flush,
  output logic                      i_gnt,
  output logic                      i_rvalid,
  output logic [31:0]               i_rdata,
  input  logic                      d_req,
  input  logic [ROM_ADDR_WIDTH-1:0] d_addr,
  output logic                      d_gnt,
  output logic                      d_rvalid,
  output logic [31:0]               d_rdata,
  output logic                      rom_rd_en,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
  input  logic [31:0]               rom_rd_data,
  output logic [CNT_WIDTH-1:0]      conflict_cnt
);

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic                 last_gnt_q, last_gnt_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 resp_port_q, resp_port_d;
  logic [CNT_WIDTH-1:0] conflict_cnt_q, conflict_cnt_d;

  logic i_eff_s;
  logic both_s;
  logic i_gnt_s;
  logic d_gnt_s;

  // Grant selection and ROM request drive; depends only on req/flush/last_gnt.
  always_comb begin
    i_eff_s   = i_req & ~i_flush;
    both_s    = i_eff_s & d_req;
    i_gnt_s   = 1'b0;
    d_gnt_s   = 1'b0;
    rom_rd_en = 1'b0;
    rom_addr  = {ROM_ADDR_WIDTH{1'b0}};

    if (both_s) begin
      // Round-robin: the port that lost (or did not use) the last grant wins.
      if (last_gnt_q == PORT_D) begin
        i_gnt_s = 1'b1;
      end else begin
        d_gnt_s = 1'b1;
      end
    end else if (i_eff_s) begin
      i_gnt_s = 1'b1;
    end else if (d_req) begin
      d_gnt_s = 1'b1;
    end else begin
      i_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end

    if (i_gnt_s) begin
      rom_rd_en = 1'b1;
      rom_addr  = i_addr;
    end else if (d_gnt_s) begin
      rom_rd_en = 1'b1;
      rom_addr  = d_addr;
    end else begin
      rom_rd_en = 1'b0;
      rom_addr  = {ROM_ADDR_WIDTH{1'b0}};
    end
  end

  assign i_gnt = i_gnt_s;
  assign d_gnt = d_gnt_s;

  // Next-state for arbitration history, pending response and conflict counter.
  always_comb begin
    last_gnt_d     = last_gnt_q;
    resp_valid_d   = 1'b0;
    resp_port_d    = resp_port_q;
    conflict_cnt_d = conflict_cnt_q;

    if (i_gnt_s | d_gnt_s) begin
      last_gnt_d   = d_gnt_s ? PORT_D : PORT_I;
      resp_valid_d = 1'b1;
      resp_port_d  = d_gnt_s ? PORT_D : PORT_I;
    end else begin
      resp_valid_d = 1'b0;
    end

    if (both_s && (conflict_cnt_q != CNT_MAX)) begin
      conflict_cnt_d = conflict_cnt_q + CNT_ONE;
    end else begin
      conflict_cnt_d = conflict_cnt_q;
    end
  end

  // State registers; reset leaves last_gnt on data so fetch wins first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q     <= PORT_D;
      resp_valid_q   <= 1'b0;
      resp_port_q    <= PORT_I;
      conflict_cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      last_gnt_q     <= last_gnt_d;
      resp_valid_q   <= resp_valid_d;
      resp_port_q    <= resp_port_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  // Response steering; a flush kills a pending fetch response in the same cycle.
  always_comb begin
    i_rvalid = resp_valid_q & (resp_port_q == PORT_I) & ~i_flush;
    d_rvalid = resp_valid_q & (resp_port_q == PORT_D);

    if (i_rvalid) begin
      i_rdata = rom_rd_data;
    end else begin
      i_rdata = 32'h0000_0000;
    end

    if (d_rvalid) begin
      d_rdata = rom_rd_data;
    end else begin
      d_rdata = 32'h0000_0000;
    end
  end

  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a behavioural synchronous ROM model.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_rom_arbiter;

  localparam int AW = 10;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_flush;
  logic          i_gnt;
  logic          i_rvalid;
  logic [31:0]   i_rdata;
  logic          d_req;
  logic [AW-1:0] d_addr;
  logic          d_gnt;
  logic          d_rvalid;
  logic [31:0]   d_rdata;
  logic          rom_rd_en;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_rd_data;
  logic [CW-1:0] conflict_cnt;

  int n_checks;
  int n_errors;

  rom_arbiter #(.ROM_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req        (i_req),
    .i_addr       (i_addr),
    .i_flush      (i_flush),
    .i_gnt        (i_gnt),
    .i_rvalid     (i_rvalid),
    .i_rdata      (i_rdata),
    .d_req        (d_req),
    .d_addr       (d_addr),
    .d_gnt        (d_gnt),
    .d_rvalid     (d_rvalid),
    .d_rdata      (d_rdata),
    .rom_rd_en    (rom_rd_en),
    .rom_addr     (rom_addr),
    .rom_rd_data  (rom_rd_data),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: a recognisable pattern per word address.
  function automatic logic [31:0] rom_val(input int a);
    logic [31:0] v;
    v = 32'hBEEF_0000 | (a & 32'h0000_03FF) | ((a & 32'h0000_000F) << 12);
    return v;
  endfunction

  // Synchronous ROM macro model.
  always @(posedge clk) begin
    if (rom_rd_en) rom_rd_data <= rom_val(int'(rom_addr));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Move to the next input slot (falling edge).
  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0; i_flush = 1'b0;
    i_addr = '0; d_addr = '0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0; i_flush = 1'b0;
    i_addr = '0; d_addr = '0;
    rom_rd_data = 32'h0;

    // ---------------- reset state ----------------
    #2;
    chk("rst_rom_rd_en", {31'd0, rom_rd_en}, 32'd0);
    chk("rst_i_rvalid", {31'd0, i_rvalid}, 32'd0);
    chk("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("rst_cnt", {28'd0, conflict_cnt}, 32'd0);
    step();
    rst_n = 1'b1;

    // ---------------- fetch-only stream 0,1,2 ----------------
    step(); i_req = 1'b1; i_addr = 10'd0; settle();
    chk("fs0_i_gnt", {31'd0, i_gnt}, 32'd1);
    chk("fs0_d_gnt", {31'd0, d_gnt}, 32'd0);
    chk("fs0_rom_addr", {22'd0, rom_addr}, 32'd0);
    chk("fs0_i_rvalid", {31'd0, i_rvalid}, 32'd0);
    for (int k = 1; k < 3; k++) begin
      step(); i_addr = AW'(k); settle();
      chk("fs_i_gnt", {31'd0, i_gnt}, 32'd1);
      chk("fs_rom_addr", {22'd0, rom_addr}, 32'(k));
      chk("fs_i_rvalid", {31'd0, i_rvalid}, 32'd1);
      chk("fs_i_rdata", i_rdata, rom_val(k - 1));
      chk("fs_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    end
    step(); i_req = 1'b0; settle();
    chk("fs3_rom_rd_en", {31'd0, rom_rd_en}, 32'd0);
    chk("fs3_rom_addr", {22'd0, rom_addr}, 32'd0);
    chk("fs3_i_rvalid", {31'd0, i_rvalid}, 32'd1);
    chk("fs3_i_rdata", i_rdata, rom_val(2));
    chk("fs3_d_rdata", d_rdata, 32'd0);
    step(); settle();
    chk("fs4_i_rvalid", {31'd0, i_rvalid}, 32'd0);
    chk("fs4_i_rdata", i_rdata, 32'd0);

    // ---------------- conflict after reset, sustained 6 cycles ----------------
    do_reset();
    i_req = 1'b1; i_addr = 10'd5; d_req = 1'b1; d_addr = 10'd9;
    for (int k = 0; k < 6; k++) begin
      settle();
      chk("cf_i_gnt", {31'd0, i_gnt}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("cf_d_gnt", {31'd0, d_gnt}, (k % 2 == 0) ? 32'd0 : 32'd1);
      chk("cf_rom_addr", {22'd0, rom_addr}, (k % 2 == 0) ? 32'd5 : 32'd9);
      chk("cf_cnt", {28'd0, conflict_cnt}, 32'(k));
      if (k > 0) begin
        chk("cf_i_rvalid", {31'd0, i_rvalid}, (k % 2 == 1) ? 32'd1 : 32'd0);
        chk("cf_i_rdata", i_rdata, (k % 2 == 1) ? rom_val(5) : 32'd0);
        chk("cf_d_rvalid", {31'd0, d_rvalid}, (k % 2 == 0) ? 32'd1 : 32'd0);
        chk("cf_d_rdata", d_rdata, (k % 2 == 0) ? rom_val(9) : 32'd0);
      end
      step();
    end
    i_req = 1'b0; d_req = 1'b0; settle();
    chk("cf6_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("cf6_d_rdata", d_rdata, rom_val(9));
    chk("cf6_i_rvalid", {31'd0, i_rvalid}, 32'd0);
    chk("cf6_cnt", {28'd0, conflict_cnt}, 32'd6);

    // ---------------- flush ----------------
    do_reset();
    i_req = 1'b1; i_addr = 10'd3; settle();
    chk("fl0_i_gnt", {31'd0, i_gnt}, 32'd1);
    step(); i_addr = 10'd4; i_flush = 1'b1; d_req = 1'b1; d_addr = 10'd7; settle();
    chk("fl1_i_rvalid", {31'd0, i_rvalid}, 32'd0);
    chk("fl1_i_rdata", i_rdata, 32'd0);
    chk("fl1_i_gnt", {31'd0, i_gnt}, 32'd0);
    chk("fl1_d_gnt", {31'd0, d_gnt}, 32'd1);
    chk("fl1_rom_addr", {22'd0, rom_addr}, 32'd7);
    step(); i_req = 1'b0; d_req = 1'b0; settle();
    chk("fl2_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("fl2_d_rdata", d_rdata, rom_val(7));
    chk("fl2_rom_rd_en", {31'd0, rom_rd_en}, 32'd0);
    chk("fl2_cnt", {28'd0, conflict_cnt}, 32'd0);
    i_flush = 1'b0;

    // ---------------- reset mid-operation ----------------
    do_reset();
    i_req = 1'b1; i_addr = 10'd1; d_req = 1'b1; d_addr = 10'd11; settle();
    chk("rm0_i_gnt", {31'd0, i_gnt}, 32'd1);
    step(); i_req = 1'b0; settle();
    chk("rm1_d_gnt", {31'd0, d_gnt}, 32'd1);
    chk("rm1_cnt", {28'd0, conflict_cnt}, 32'd1);
    step(); d_req = 1'b0; rst_n = 1'b0; settle();
    chk("rm2_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("rm2_d_rdata", d_rdata, 32'd0);
    chk("rm2_rom_rd_en", {31'd0, rom_rd_en}, 32'd0);
    chk("rm2_cnt", {28'd0, conflict_cnt}, 32'd0);
    step(); rst_n = 1'b1; settle();
    chk("rm3_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("rm3_i_rvalid", {31'd0, i_rvalid}, 32'd0);
    step(); i_req = 1'b1; d_req = 1'b1; settle();
    chk("rm4_i_gnt", {31'd0, i_gnt}, 32'd1);
    chk("rm4_d_gnt", {31'd0, d_gnt}, 32'd0);

    // ---------------- saturation with 4-bit counter ----------------
    do_reset();
    i_req = 1'b1; d_req = 1'b1; i_addr = 10'd2; d_addr = 10'd6;
    for (int k = 1; k <= 20; k++) begin
      step(); settle();
      chk("sat_cnt", {28'd0, conflict_cnt}, (k < 15) ? 32'(k) : 32'd15);
    end
    step(); i_req = 1'b0; d_req = 1'b0; settle();
    chk("sat_final", {28'd0, conflict_cnt}, 32'd15);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-port arbiter that shares the single-port synchronous instruction ROM between the instruction-fetch path and the data-bus load path (read-only constant/data loads from the ROM region). It sits between the instruction bus and the data bus on one side and the ROM macro on the other. It issues at most one ROM read per cycle, chooses a requester round-robin on conflict, and routes the 1-cycle-latency read data back to the port that issued the read. Address decode and access-fault checks happen upstream; this block sees only word addresses already inside the ROM.

## Interface
- ROM_ADDR_WIDTH, DEFAULT_ROM_ADDR_WIDTH, word-address width of the ROM
- CNT_WIDTH, 16, width of the saturating conflict counter
- clk  input  1  core clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- i_req  input  1  fetch read request; held with i_addr until i_gnt
- i_addr  input  ROM_ADDR_WIDTH  fetch word address
- i_flush  input  1  fetch redirect; discards fetch response and fetch grant this cycle
- i_gnt  output  1  fetch request accepted this cycle (combinational)
- i_rvalid  output  1  fetch read data valid
- i_rdata  output  32  fetch read data; 0 when i_rvalid=0
- d_req  input  1  data-bus read request; held with d_addr until d_gnt
- d_addr  input  ROM_ADDR_WIDTH  data word address
- d_gnt  output  1  data request accepted this cycle (combinational)
- d_rvalid  output  1  data read data valid
- d_rdata  output  32  data read data; 0 when d_rvalid=0
- rom_rd_en  output  1  ROM read enable
- rom_addr  output  ROM_ADDR_WIDTH  ROM word address; 0 when rom_rd_en=0
- rom_rd_data  input  32  ROM data, valid the cycle after rom_rd_en
- conflict_cnt  output  CNT_WIDTH  count of cycles in which both ports requested

## Operation
- State: last_gnt (0=fetch, 1=data), resp_valid, resp_port, conflict_cnt.
- Effective fetch request: i_req & ~i_flush.
- Grant rules, evaluated combinationally each cycle:
  - Only one effective request: grant it.
  - Both requesting: grant the port that is not last_gnt.
  - No request: no grant, rom_rd_en=0.
- On any grant: rom_rd_en=1, rom_addr=the granted port's address, last_gnt←granted port, resp_valid←1, resp_port←granted port.
- With no grant: resp_valid←0.
- Response routing: in the cycle after the grant, rom_rd_data is driven to the rdata of resp_port, and that port's rvalid=1. The other port sees rvalid=0 and rdata=0.
- Flush: when i_flush=1 and resp_port=fetch, i_rvalid is forced to 0 in that same cycle (combinational kill). Data responses are never affected by i_flush.
- A requester whose grant is denied keeps its request; it wins the next conflict by round-robin. Worst-case wait is 1 cycle.
- conflict_cnt increments, saturating at all-ones, in each cycle where i_req & ~i_flush & d_req.
- Reset values: last_gnt=1, so fetch wins the first conflict. resp_valid=0, conflict_cnt=0, all rvalid/rdata=0, rom_rd_en=0.

## Timing
- Grant is 0-cycle, combinational from req/flush/last_gnt.
- Read latency: 1 cycle from gnt to rvalid.
- Throughput: one read per cycle, fully pipelined. Back-to-back grants to the same or alternating ports are legal.
- Registered state updates only on the rising edge of clk. rst_n assertion clears the state immediately, without waiting for a clock edge.
- Reset mid-read: a response pending at reset is dropped, and no rvalid appears after rst_n deasserts.
- i_flush in the same cycle as a pending fetch response and a new fetch request: the response is killed, no fetch grant is issued, and d may be granted.
- No combinational path from rom_rd_data to any gnt.

## Test plan
- Fetch-only stream: i_req=1 with addrs 0,1,2 on consecutive cycles. Required: i_gnt=1 every cycle, and i_rvalid=1 one cycle later with i_rdata=ROM[0],ROM[1],ROM[2]. d_rvalid stays 0.
- Conflict after reset: i_req=d_req=1, i_addr=5, d_addr=9, held. Required:
  - fetch granted in cycle 0 and data in cycle 1.
  - i_rdata=ROM[5] in cycle 1 and d_rdata=ROM[9] in cycle 2.
  - conflict_cnt=1 after cycle 0. It then increments for each further both-requesting cycle, counting only cycles where i_req & ~i_flush & d_req.
- Sustained conflict for 6 cycles: grants alternate i,d,i,d,i,d and conflict_cnt=6.
- Flush: fetch granted at addr 3, then i_flush=1 in the response cycle. Required: i_rvalid=0 and i_rdata=0 that cycle. With i_req=1 also held, i_gnt=0 that cycle. A d request in the same cycle is still granted.
- Reset mid-operation: assert rst_n=0 the cycle after a data grant. Required: d_rvalid=0 immediately, and all outputs at reset values. After release, fetch wins the first conflict.
- Saturation: with CNT_WIDTH=4, drive 20 conflict cycles. Required: conflict_cnt holds at 15.
